pc_sequencer: RTL and testbench

//  Next-PC controller for the pipelined CPU. It selects npc and drives the PC register's en each cycle.

---
 rtl/pc_sequencer.sv | 121 ++++++++++++
 tb/tb_pc_sequencer.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/pc_sequencer.sv
// Next-PC controller: picks npc from interrupt entry, eret, branch/jump or pc+4,
// drives the PC load enable and IF/ID flush, and holds EPC and the EXL bit.
module pc_sequencer #(
  parameter logic [31:0] RESET_PC   = 32'h0000_3000,
  parameter logic [31:0] HANDLER_PC = 32'h0000_4180,
  parameter int          IRQ_SYNC   = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] pc,
  input  logic        stall,
  input  logic        br_taken,
  input  logic [31:0] br_target,
  input  logic        jmp,
  input  logic [31:0] jmp_target,
  input  logic        eret,
  input  logic        irq,
  output logic [31:0] npc,
  output logic        pc_en,
  output logic        flush,
  output logic [31:0] epc,
  output logic        exl
);

  typedef enum logic [1:0] {
    S_RUN     = 2'd0,
    S_TAKE    = 2'd1,
    S_HANDLER = 2'd2
  } state_t;

  state_t               r_state;
  state_t               w_state_nxt;
  logic [IRQ_SYNC-1:0]  r_irq_sync;
  logic [31:0]          r_epc;
  logic                 r_exl;
  logic                 w_irq_s;
  logic [31:0]          w_pc_plus4;
  logic [31:0]          w_seq_npc;
  logic                 w_epc_load;
  logic                 w_exl_set;
  logic                 w_exl_clr;

  assign w_irq_s    = r_irq_sync[IRQ_SYNC-1];
  assign w_pc_plus4 = pc + 32'd4;
  assign w_seq_npc  = jmp ? jmp_target : (br_taken ? br_target : w_pc_plus4);

  // NOTE: clocked state uses <= so every flop samples pre-edge values; '=' here would
  // let the synchronizer collapse into a single stage.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_irq_sync <= '0;
    end else begin
      r_irq_sync <= {r_irq_sync[IRQ_SYNC-2:0], irq};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_RUN;
      r_epc   <= {RESET_PC[31:2], 2'b00};
      r_exl   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (w_epc_load) r_epc <= {w_seq_npc[31:2], 2'b00};
      if (w_exl_set)       r_exl <= 1'b1;
      else if (w_exl_clr)  r_exl <= 1'b0;
    end
  end

  // NOTE: every output and control strobe gets a default before the case so no
  // path through the block can leave one unassigned and infer a latch.
  always_comb begin
    w_state_nxt = r_state;
    npc         = w_seq_npc;
    pc_en       = ~stall;
    flush       = 1'b0;
    w_epc_load  = 1'b0;
    w_exl_set   = 1'b0;
    w_exl_clr   = 1'b0;
    if (rst) begin
      npc = w_pc_plus4;
    end else begin
      unique case (r_state)
        S_RUN: begin
          // Interrupt wins over any redirect; the redirect target becomes the return address.
          if (w_irq_s) begin
            pc_en = 1'b0;
            if (!stall) begin
              flush       = 1'b1;
              w_epc_load  = 1'b1;
              w_state_nxt = S_TAKE;
            end
          end
        end
        S_TAKE: begin
          npc         = HANDLER_PC;
          pc_en       = 1'b1;
          flush       = 1'b1;
          w_exl_set   = 1'b1;
          w_state_nxt = S_HANDLER;
        end
        S_HANDLER: begin
          if (eret) begin
            npc   = r_epc;
            pc_en = ~stall;
            flush = ~stall;
            if (!stall) begin
              w_exl_clr   = 1'b1;
              w_state_nxt = S_RUN;
            end
          end
        end
        default: w_state_nxt = S_RUN;
      endcase
    end
  end

  assign epc = r_epc;
  assign exl = r_exl;

endmodule

// File: tb/tb_pc_sequencer.sv
// Bench for pc_sequencer: directed vector table, reset-during-entry sequence,
// then randomized traffic checked against a rule-level reference model.
module tb_pc_sequencer;

  localparam logic [31:0] RESET_PC   = 32'h0000_3000;
  localparam logic [31:0] HANDLER_PC = 32'h0000_4180;
  localparam int          IRQ_SYNC   = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] pc;
  logic        stall;
  logic        br_taken;
  logic [31:0] br_target;
  logic        jmp;
  logic [31:0] jmp_target;
  logic        eret;
  logic        irq;
  logic [31:0] npc;
  logic        pc_en;
  logic        flush;
  logic [31:0] epc;
  logic        exl;

  int n_cmp = 0;
  int n_err = 0;

  pc_sequencer #(.RESET_PC(RESET_PC), .HANDLER_PC(HANDLER_PC), .IRQ_SYNC(IRQ_SYNC)) dut (
    .clk(clk), .rst(rst), .pc(pc), .stall(stall),
    .br_taken(br_taken), .br_target(br_target),
    .jmp(jmp), .jmp_target(jmp_target),
    .eret(eret), .irq(irq),
    .npc(npc), .pc_en(pc_en), .flush(flush), .epc(epc), .exl(exl)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic [31:0] pc;
    logic        stall;
    logic        br;
    logic [31:0] bt;
    logic        jmp;
    logic [31:0] jt;
    logic        eret;
    logic        irq;
    logic [31:0] e_npc;
    logic        e_en;
    logic        e_fl;
    logic [31:0] e_epc;
    logic        e_exl;
  } vec_t;

  function automatic vec_t v(input logic r, input logic [31:0] p, input logic s,
                             input logic b, input logic [31:0] bt, input logic j,
                             input logic [31:0] jt, input logic e, input logic q,
                             input logic [31:0] xn, input logic xe, input logic xf,
                             input logic [31:0] xp, input logic xx);
    vec_t t;
    t.rst = r; t.pc = p; t.stall = s; t.br = b; t.bt = bt; t.jmp = j; t.jt = jt;
    t.eret = e; t.irq = q; t.e_npc = xn; t.e_en = xe; t.e_fl = xf; t.e_epc = xp; t.e_exl = xx;
    return t;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s @%0t: got %h, expected %h", name, $time, act, exp);
    end
  endtask

  task automatic drive(input logic r, input logic [31:0] p, input logic s, input logic b,
                       input logic [31:0] bt, input logic j, input logic [31:0] jt,
                       input logic e, input logic q);
    rst = r; pc = p; stall = s; br_taken = b; br_target = bt;
    jmp = j; jmp_target = jt; eret = e; irq = q;
  endtask

  task automatic check_all(input string tag, input logic [31:0] xn, input logic xe,
                           input logic xf, input logic [31:0] xp, input logic xx);
    check({tag, ".npc"},   npc,   xn);
    check({tag, ".pc_en"}, {31'd0, pc_en}, {31'd0, xe});
    check({tag, ".flush"}, {31'd0, flush}, {31'd0, xf});
    check({tag, ".epc"},   epc,   xp);
    check({tag, ".exl"},   {31'd0, exl},   {31'd0, xx});
  endtask

  // Reference model: rule-level description of the sequencer.
  bit          m_entering;
  bit          m_in_handler;
  logic [31:0] m_epc;
  logic        irq_log[$];

  function automatic logic model_irq_s();
    if (irq_log.size() >= IRQ_SYNC) return irq_log[irq_log.size() - IRQ_SYNC];
    return 1'b0;
  endfunction

  function automatic logic [31:0] model_seq();
    if (jmp) return jmp_target;
    if (br_taken) return br_target;
    return pc + 32'd4;
  endfunction

  task automatic model_reset();
    m_entering = 0; m_in_handler = 0; m_epc = RESET_PC; irq_log.delete();
  endtask

  task automatic model_expect(output logic [31:0] xn, output logic xe, output logic xf);
    logic [31:0] seq;
    seq = model_seq();
    if (rst) begin
      xn = pc + 32'd4; xe = ~stall; xf = 1'b0;
    end else if (m_entering) begin
      xn = HANDLER_PC; xe = 1'b1; xf = 1'b1;
    end else if (m_in_handler && eret) begin
      xn = m_epc; xe = ~stall; xf = ~stall;
    end else if (!m_in_handler && model_irq_s()) begin
      xn = seq; xe = 1'b0; xf = ~stall;
    end else begin
      xn = seq; xe = ~stall; xf = 1'b0;
    end
  endtask

  task automatic model_clock();
    logic [31:0] seq;
    if (rst) return;
    seq = model_seq();
    if (m_entering) begin
      m_entering = 0; m_in_handler = 1;
    end else if (m_in_handler) begin
      if (eret && !stall) m_in_handler = 0;
    end else if (model_irq_s() && !stall) begin
      m_epc = {seq[31:2], 2'b00};
      m_entering = 1;
    end
    irq_log.push_back(irq);
    if (irq_log.size() > IRQ_SYNC) void'(irq_log.pop_front());
  endtask

  vec_t tbl[$];

  initial begin
    logic [31:0] xn;
    logic        xe, xf;
    logic        r_irq_lvl;

    drive(1, RESET_PC, 0, 0, 0, 0, 0, 0, 0);
    repeat (2) @(posedge clk);

    //       rst pc           st br bt           j  jt           e  q   npc          en fl epc          exl
    tbl.push_back(v(1, 32'h3000, 0, 0, 0,           0, 0,           0, 0, 32'h3004, 1, 0, 32'h3000, 0));
    tbl.push_back(v(0, 32'h3000, 0, 0, 0,           0, 0,           0, 0, 32'h3004, 1, 0, 32'h3000, 0));
    tbl.push_back(v(0, 32'h3010, 1, 1, 32'h3100,    0, 0,           0, 0, 32'h3100, 0, 0, 32'h3000, 0));
    tbl.push_back(v(0, 32'h3010, 0, 1, 32'h3100,    0, 0,           0, 0, 32'h3100, 1, 0, 32'h3000, 0));
    tbl.push_back(v(0, 32'h3020, 0, 0, 0,           0, 0,           0, 1, 32'h3024, 1, 0, 32'h3000, 0));
    tbl.push_back(v(0, 32'h3020, 0, 0, 0,           0, 0,           0, 0, 32'h3024, 1, 0, 32'h3000, 0));
    tbl.push_back(v(0, 32'h3020, 0, 0, 0,           0, 0,           0, 0, 32'h3024, 0, 1, 32'h3000, 0));
    tbl.push_back(v(0, 32'h3020, 0, 0, 0,           0, 0,           0, 0, 32'h4180, 1, 1, 32'h3024, 0));
    tbl.push_back(v(0, 32'h4180, 0, 0, 0,           0, 0,           0, 1, 32'h4184, 1, 0, 32'h3024, 1));
    tbl.push_back(v(0, 32'h4184, 0, 0, 0,           0, 0,           0, 1, 32'h4188, 1, 0, 32'h3024, 1));
    tbl.push_back(v(0, 32'h4188, 0, 1, 32'h5000,    0, 0,           1, 1, 32'h3024, 1, 1, 32'h3024, 1));
    tbl.push_back(v(0, 32'h3024, 0, 0, 0,           0, 0,           0, 1, 32'h3028, 0, 1, 32'h3024, 0));
    tbl.push_back(v(0, 32'h3024, 0, 0, 0,           0, 0,           0, 0, 32'h4180, 1, 1, 32'h3028, 0));
    tbl.push_back(v(0, 32'h4180, 1, 0, 0,           0, 0,           1, 0, 32'h3028, 0, 0, 32'h3028, 1));
    tbl.push_back(v(0, 32'h4180, 0, 0, 0,           0, 0,           1, 0, 32'h3028, 1, 1, 32'h3028, 1));
    tbl.push_back(v(0, 32'h3028, 0, 0, 0,           0, 0,           0, 0, 32'h302C, 1, 0, 32'h3028, 0));
    tbl.push_back(v(0, 32'h3030, 0, 1, 32'h3300,    1, 32'h3200,    0, 1, 32'h3200, 1, 0, 32'h3028, 0));
    tbl.push_back(v(0, 32'h3030, 0, 0, 0,           1, 32'h3200,    0, 0, 32'h3200, 1, 0, 32'h3028, 0));
    tbl.push_back(v(0, 32'h3030, 0, 0, 0,           1, 32'h3200,    0, 0, 32'h3200, 0, 1, 32'h3028, 0));
    tbl.push_back(v(0, 32'h3030, 0, 0, 0,           0, 0,           0, 0, 32'h4180, 1, 1, 32'h3200, 0));
    tbl.push_back(v(0, 32'h4180, 0, 0, 0,           0, 0,           1, 0, 32'h3200, 1, 1, 32'h3200, 1));
    tbl.push_back(v(0, 32'h3200, 0, 0, 0,           0, 0,           1, 0, 32'h3204, 1, 0, 32'h3200, 0));
    tbl.push_back(v(0, 32'hFFFF_FFFC, 0, 0, 0,      0, 0,           0, 0, 32'h0000, 1, 0, 32'h3200, 0));
    tbl.push_back(v(0, 32'h3010, 0, 1, 32'h3500,    1, 32'h3400,    0, 0, 32'h3400, 1, 0, 32'h3200, 0));
    tbl.push_back(v(0, 32'h3040, 1, 0, 0,           0, 0,           0, 1, 32'h3044, 0, 0, 32'h3200, 0));
    tbl.push_back(v(0, 32'h3040, 1, 0, 0,           0, 0,           0, 1, 32'h3044, 0, 0, 32'h3200, 0));
    tbl.push_back(v(0, 32'h3040, 1, 0, 0,           0, 0,           0, 1, 32'h3044, 0, 0, 32'h3200, 0));
    tbl.push_back(v(0, 32'h3040, 0, 0, 0,           0, 0,           0, 0, 32'h3044, 0, 1, 32'h3200, 0));

    foreach (tbl[i]) begin
      @(negedge clk);
      drive(tbl[i].rst, tbl[i].pc, tbl[i].stall, tbl[i].br, tbl[i].bt,
            tbl[i].jmp, tbl[i].jt, tbl[i].eret, tbl[i].irq);
      #1;
      check_all($sformatf("vec%0d", i), tbl[i].e_npc, tbl[i].e_en, tbl[i].e_fl,
                tbl[i].e_epc, tbl[i].e_exl);
    end

    // Reset arriving in the middle of the handler-entry cycle.
    @(negedge clk);
    drive(0, 32'h3040, 0, 0, 0, 0, 0, 0, 0);
    #1;
    check_all("take", HANDLER_PC, 1, 1, 32'h3044, 0);
    #2 rst = 1'b1;
    #1;
    check_all("rst_in_take", 32'h3044, 1, 0, RESET_PC, 0);
    @(negedge clk);
    drive(0, 32'h3000, 0, 0, 0, 0, 0, 0, 0);
    #1;
    check_all("after_rst", 32'h3004, 1, 0, RESET_PC, 0);

    // Randomized traffic against the reference model.
    @(negedge clk);
    drive(1, RESET_PC, 0, 0, 0, 0, 0, 0, 0);
    model_reset();
    @(posedge clk);
    r_irq_lvl = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      if ($urandom_range(7) == 0) r_irq_lvl = ~r_irq_lvl;
      drive(($urandom_range(99) == 0),
            ($urandom_range(15) == 0) ? 32'hFFFF_FFFC : $urandom(),
            ($urandom_range(3) == 0),
            ($urandom_range(3) == 0), $urandom(),
            ($urandom_range(6) == 0), $urandom(),
            ($urandom_range(3) == 0), r_irq_lvl);
      if (rst) model_reset();
      #1;
      model_expect(xn, xe, xf);
      check_all($sformatf("rnd%0d", c), xn, xe, xf, m_epc, m_in_handler);
      @(posedge clk);
      model_clock();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
